sp_ctrl_unit: RTL and testbench
===============================

Name: sp_ctrl_unit

Overview:
Per-core sequencer that sits directly upstream of the SP core ALU. It fetches 16-bit instructions from a synchronous instruction memory and decodes them. It drives the ALU opcode and the register-file read addresses, then commits results: register write-enable for value ops, or an internal predicate register sampled from the ALU P output. It also handles predicated branches, the inter-core SYNC barrier and HALT.

Parameters:
PC_W, 8, program counter / imem address width (1..16)
START_PC, 0, PC value loaded on reset and on start

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin execution at START_PC; sampled only in IDLE or HALTED
imem_addr  out  PC_W  instruction address (registered)
imem_en  out  1  read strobe; data valid on imem_data the next cycle
imem_data  in  16  instruction word: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2; imm8 = [7:0]
alu_c  out  4  ALU opcode
alu_p  in  1  ALU predicate output
rf_a_addr  out  4  register driven to ALU A
rf_b_addr  out  4  register driven to ALU B
rf_c_addr  out  4  register driven to ALU C
rf_we  out  1  register-file write strobe (ALU_OUT written)
rf_waddr  out  4  write register
pred  out  1  current predicate register
sync_req  out  1  core waiting at barrier
sync_go  in  1  barrier release
busy  out  1  high in FETCH..SYNC_WAIT
halted  out  1  high in HALTED
instr_retired  out  16  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (async, immediate): state=IDLE, pc=START_PC, IR=0, pred=0, imem_en=0, imem_addr=START_PC, rf_we=0, rf_waddr=0, alu_c=4'b1111, rf_*_addr=0, sync_req=0, busy=0, halted=0, instr_retired=0. Reset mid-instruction discards all in-flight work.
- States: IDLE, FETCH, DECODE, EXEC, WB, SYNC_WAIT, HALTED.
- IDLE/HALTED: on start=1, pc<=START_PC and go to FETCH. start is ignored in all other states.
- FETCH: imem_addr=pc, imem_en=1 for this cycle only; go to DECODE.
- DECODE: IR<=imem_data; go to EXEC.
- EXEC: alu_c and rf addresses are driven from IR; the ALU settles combinationally.
- alu_c=4'b1111 (ALU hold code) in every state except EXEC and WB.
- Op map, given as op -> alu_c, A/B/C addresses, commit:
  - 0 NOP -> none
  - 1 CLR -> 0000, write rd
  - 2 INC -> 0001, A=rd, write rd
  - 3 ADD -> 0010, B=rs1, C=rs2, write rd
  - 4 MUL -> 0011, B=rs1, C=rs2, write rd
  - 5 MAD -> 0100, A=rd, B=rs1, C=rs2, write rd
  - 6/7/8/9 SETP EQ/LT/GT/NEQ -> 0101/0110/0111/1000, A=rs1, B=rs2, pred<=alu_p at end of WB
  - A CID -> 1001, write rd
  - B NCORES -> 1010, write rd
  - C BRP -> if pred, pc<=imm8 else pc+1
  - D JMP -> pc<=imm8
  - E SYNC
  - F HALT
- Value and SETP ops: EXEC -> WB. In WB, alu_c and addresses are held; rf_we=1 with rf_waddr=rd for exactly one cycle (value ops), or pred is updated (SETP); pc<=pc+1; go to FETCH. Latency is 4 cycles per instruction.
- NOP/BRP/JMP: resolve in EXEC, go directly to FETCH (3 cycles).
- Branch target: imm8 zero-extended or truncated to PC_W. BRP uses pred as it was before this instruction.
- pc+1 wraps modulo 2^PC_W; no fault.
- SYNC: EXEC -> SYNC_WAIT with sync_req=1. When sync_go=1 (including the first cycle of waiting): sync_req<=0, pc<=pc+1, go to FETCH. sync_go outside SYNC_WAIT is ignored.
- HALT: EXEC -> HALTED; pc is retained; halted=1, busy=0.
- Only the controller registers pred; the ALU P value is never forwarded without WB.

Optional Feature:
Macro SP_CTRL_PERF_CNT_EN.
- Defined: instr_retired increments by 1 when an instruction leaves EXEC/WB/SYNC_WAIT toward FETCH or HALTED; it wraps at 16'hFFFF->0, clears on reset, and is not cleared by start.
- Undefined: instr_retired is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset mid-WB of ADD -> rf_we drops immediately, state=IDLE, pc=START_PC, alu_c=4'hF, pred=0.
- Program ADD r3,r1,r2 (0x3312) with r1=5, r2=7 -> alu_c=0010, rf_b_addr=1, rf_c_addr=2 in EXEC; rf_we=1, rf_waddr=3 for one cycle in WB; next fetch at pc=1 four cycles after the first FETCH.
- SETP_LT r1,r2 (0x7012) with alu_p=1, then BRP 0x20 (0xC020) -> pred=1, next imem_addr=0x20. Repeat with alu_p=0 -> next imem_addr = BRP pc+1.
- JMP 0xFF with PC_W=8, then NOP at 0xFF -> next fetch address 0x00 (wrap).
- SYNC with sync_go held low 5 cycles -> sync_req=1 for those cycles, busy=1. Pulse sync_go -> sync_req=0 next cycle, FETCH pc+1. A sync_go pulse during EXEC of a preceding op has no effect.
- 3 instructions then HALT with SP_CTRL_PERF_CNT_EN -> halted=1, instr_retired=4, start ignored while busy. start in HALTED restarts at START_PC. Without the macro, instr_retired=0 throughout.

Source files
------------

// File: rtl/sp_ctrl_unit.sv
// sp_ctrl_unit: per-core fetch/decode/commit sequencer feeding the SP core ALU.
// Optional feature: define SP_CTRL_PERF_CNT_EN to build the retired-instruction counter.
module sp_ctrl_unit #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_en,
  input  logic [15:0]     imem_data,
  output logic [3:0]      alu_c,
  input  logic            alu_p,
  output logic [3:0]      rf_a_addr,
  output logic [3:0]      rf_b_addr,
  output logic [3:0]      rf_c_addr,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic            pred,
  output logic            sync_req,
  input  logic            sync_go,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     instr_retired
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_CLR  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_MAD  = 4'h5;
  localparam logic [3:0] OP_SEQ  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SGT  = 4'h8;
  localparam logic [3:0] OP_SNE  = 4'h9;
  localparam logic [3:0] OP_CID  = 4'hA;
  localparam logic [3:0] OP_NCR  = 4'hB;
  localparam logic [3:0] OP_BRP  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_SYNC = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_HOLD = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_SYNC_WAIT,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
  } alu_ctl_t;

  localparam alu_ctl_t CTL_IDLE = '{op: ALU_HOLD, a: 4'h0, b: 4'h0, c: 4'h0};

  // ALU opcode and operand addresses for one instruction word.
  function automatic alu_ctl_t decode_alu(input logic [15:0] ins);
    alu_ctl_t ctl;
    ctl = CTL_IDLE;
    case (ins[15:12])
      OP_CLR: ctl.op = 4'b0000;
      OP_INC: begin ctl.op = 4'b0001; ctl.a = ins[11:8]; end
      OP_ADD: begin ctl.op = 4'b0010; ctl.b = ins[7:4]; ctl.c = ins[3:0]; end
      OP_MUL: begin ctl.op = 4'b0011; ctl.b = ins[7:4]; ctl.c = ins[3:0]; end
      OP_MAD: begin
        ctl.op = 4'b0100; ctl.a = ins[11:8]; ctl.b = ins[7:4]; ctl.c = ins[3:0];
      end
      OP_SEQ: begin ctl.op = 4'b0101; ctl.a = ins[7:4]; ctl.b = ins[3:0]; end
      OP_SLT: begin ctl.op = 4'b0110; ctl.a = ins[7:4]; ctl.b = ins[3:0]; end
      OP_SGT: begin ctl.op = 4'b0111; ctl.a = ins[7:4]; ctl.b = ins[3:0]; end
      OP_SNE: begin ctl.op = 4'b1000; ctl.a = ins[7:4]; ctl.b = ins[3:0]; end
      OP_CID: ctl.op = 4'b1001;
      OP_NCR: ctl.op = 4'b1010;
      default: ctl = CTL_IDLE;
    endcase
    return ctl;
  endfunction

  // Ops that write ALU_OUT back to rd.
  function automatic logic is_value(input logic [3:0] op);
    return (op == OP_CLR) || (op == OP_INC) || (op == OP_ADD) || (op == OP_MUL) ||
           (op == OP_MAD) || (op == OP_CID) || (op == OP_NCR);
  endfunction

  // Ops that commit the ALU predicate.
  function automatic logic is_setp(input logic [3:0] op);
    return (op == OP_SEQ) || (op == OP_SLT) || (op == OP_SGT) || (op == OP_SNE);
  endfunction

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            pred_d;
  logic            imem_en_d;
  logic [PC_W-1:0] imem_addr_d;
  alu_ctl_t        ctl_q, ctl_d;
  logic            rf_we_d;
  logic [3:0]      rf_waddr_d;
  logic            sync_req_d;
  logic            busy_d;
  logic            halted_d;

  logic [3:0]      ir_op;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_target;

  assign ir_op     = ir_q[15:12];
  assign pc_inc    = pc_q + PC_W'(1);
  assign br_target = PC_W'(ir_q[7:0]);

  assign alu_c     = ctl_q.op;
  assign rf_a_addr = ctl_q.a;
  assign rf_b_addr = ctl_q.b;
  assign rf_c_addr = ctl_q.c;

  // Next-state sequencing plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    pred_d      = pred;
    imem_en_d   = 1'b0;
    imem_addr_d = imem_addr;
    ctl_d       = CTL_IDLE;
    rf_we_d     = 1'b0;
    rf_waddr_d  = 4'h0;
    sync_req_d  = 1'b0;
    busy_d      = 1'b0;
    halted_d    = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (ir_op)
          OP_NOP:  begin pc_d = pc_inc; state_d = S_FETCH; end
          OP_BRP:  begin pc_d = pred ? br_target : pc_inc; state_d = S_FETCH; end
          OP_JMP:  begin pc_d = br_target; state_d = S_FETCH; end
          OP_SYNC: state_d = S_SYNC_WAIT;
          OP_HALT: state_d = S_HALTED;
          default: state_d = S_WB;
        endcase
      end
      S_WB: begin
        if (is_setp(ir_op)) begin
          pred_d = alu_p;
        end
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_SYNC_WAIT: begin
        if (sync_go) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    imem_en_d = (state_d == S_FETCH);
    if (imem_en_d) begin
      imem_addr_d = pc_d;
    end
    if ((state_d == S_EXEC) || (state_d == S_WB)) begin
      ctl_d = decode_alu(ir_d);
    end
    rf_we_d    = (state_d == S_WB) && is_value(ir_op);
    rf_waddr_d = rf_we_d ? ir_q[11:8] : 4'h0;
    sync_req_d = (state_d == S_SYNC_WAIT);
    busy_d     = (state_d != S_IDLE) && (state_d != S_HALTED);
    halted_d   = (state_d == S_HALTED);
  end

  // State, architectural registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= START_PC;
      ir_q      <= 16'h0000;
      pred      <= 1'b0;
      imem_en   <= 1'b0;
      imem_addr <= START_PC;
      ctl_q     <= CTL_IDLE;
      rf_we     <= 1'b0;
      rf_waddr  <= 4'h0;
      sync_req  <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pred      <= pred_d;
      imem_en   <= imem_en_d;
      imem_addr <= imem_addr_d;
      ctl_q     <= ctl_d;
      rf_we     <= rf_we_d;
      rf_waddr  <= rf_waddr_d;
      sync_req  <= sync_req_d;
      busy      <= busy_d;
      halted    <= halted_d;
    end
  end

`ifdef SP_CTRL_PERF_CNT_EN
  logic        retire_c;
  logic [15:0] retired_q;

  // An instruction retires when it leaves its last execute-side state.
  always_comb begin
    retire_c = ((state_q == S_EXEC) || (state_q == S_WB) || (state_q == S_SYNC_WAIT)) &&
               ((state_d == S_FETCH) || (state_d == S_HALTED));
  end

  // Free-running retired count; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= 16'h0000;
    end else if (retire_c) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign instr_retired = retired_q;
`else
  assign instr_retired = 16'h0000;
`endif

endmodule

// File: tb/tb_sp_ctrl_unit.sv
// tb_sp_ctrl_unit: directed program with randomized fields, checked against an
// instruction-level model of the sequencer.
module tb_sp_ctrl_unit;

  localparam int unsigned     PC_W     = 8;
  localparam logic [PC_W-1:0] START_PC = 8'h00;

`ifdef SP_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic            imem_en;
  logic [15:0]     imem_data = 16'h0000;
  logic [3:0]      alu_c;
  logic            alu_p;
  logic [3:0]      rf_a_addr, rf_b_addr, rf_c_addr;
  logic            rf_we;
  logic [3:0]      rf_waddr;
  logic            pred;
  logic            sync_req;
  logic            sync_go;
  logic            busy;
  logic            halted;
  logic [15:0]     instr_retired;

  sp_ctrl_unit #(.PC_W(PC_W), .START_PC(START_PC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
    .alu_c(alu_c), .alu_p(alu_p),
    .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr), .rf_c_addr(rf_c_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .pred(pred),
    .sync_req(sync_req), .sync_go(sync_go),
    .busy(busy), .halted(halted), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (imem_en) imem_data <= mem[imem_addr];
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Instruction-level model state.
  logic [PC_W-1:0] m_pc;
  logic            m_pred;
  logic [15:0]     m_ret;
  logic            rnd_p [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ret();
    return PERF ? 32'(m_ret) : 32'd0;
  endfunction

  function automatic bit m_value(input logic [3:0] op);
    return ((op >= 4'h1) && (op <= 4'h5)) || (op == 4'hA) || (op == 4'hB);
  endfunction

  function automatic bit m_setp(input logic [3:0] op);
    return (op >= 4'h6) && (op <= 4'h9);
  endfunction

  // {alu_c, A, B, C} expected while the instruction is in EXEC/WB.
  function automatic logic [15:0] model_ctl(input logic [15:0] ins);
    logic [3:0] op, rd, rs1, rs2;
    op = ins[15:12]; rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0];
    case (op)
      4'h1: return {4'h0, 4'h0, 4'h0, 4'h0};
      4'h2: return {4'h1, rd, 4'h0, 4'h0};
      4'h3: return {4'h2, 4'h0, rs1, rs2};
      4'h4: return {4'h3, 4'h0, rs1, rs2};
      4'h5: return {4'h4, rd, rs1, rs2};
      4'h6, 4'h7, 4'h8, 4'h9: return {op - 4'h1, rs1, rs2, 4'h0};
      4'hA: return {4'h9, 4'h0, 4'h0, 4'h0};
      4'hB: return {4'hA, 4'h0, 4'h0, 4'h0};
      default: return {4'hF, 4'h0, 4'h0, 4'h0};
    endcase
  endfunction

  // Run one instruction starting in its FETCH cycle, checking each cycle.
  task automatic step(input bit ap, input bit stop_wb, input int wait_n,
                      input bit go_exec, input bit hold_start);
    logic [15:0] ins, ctl;
    logic [3:0]  op;
    @(negedge clk);
    chk("sync_req_after", 32'(sync_req), 32'd0);
    sync_go = 1'b0;
    start   = hold_start;
    chk("fetch_en", 32'(imem_en), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
    chk("fetch_busy", 32'(busy), 32'd1);
    chk("fetch_alu_hold", 32'(alu_c), 32'hF);
    chk("pred", 32'(pred), 32'(m_pred));
    chk("retired", 32'(instr_retired), exp_ret());
    ins = mem[m_pc];
    op  = ins[15:12];
    ctl = model_ctl(ins);
    @(negedge clk);
    chk("decode_en", 32'(imem_en), 32'd0);
    chk("decode_alu_hold", 32'(alu_c), 32'hF);
    @(negedge clk);
    alu_p = ap;
    if (go_exec) sync_go = 1'b1;
    chk("exec_alu_c", 32'(alu_c), 32'(ctl[15:12]));
    chk("exec_a", 32'(rf_a_addr), 32'(ctl[11:8]));
    chk("exec_b", 32'(rf_b_addr), 32'(ctl[7:4]));
    chk("exec_c", 32'(rf_c_addr), 32'(ctl[3:0]));
    chk("exec_we", 32'(rf_we), 32'd0);
    if (m_value(op) || m_setp(op)) begin
      @(negedge clk);
      sync_go = 1'b0;
      chk("wb_we", 32'(rf_we), 32'(m_value(op)));
      if (m_value(op)) chk("wb_waddr", 32'(rf_waddr), 32'(ins[11:8]));
      chk("wb_alu_c", 32'(alu_c), 32'(ctl[15:12]));
      chk("wb_b", 32'(rf_b_addr), 32'(ctl[7:4]));
      if (stop_wb) return;
      m_pc = m_pc + 1'b1;
      if (m_setp(op)) m_pred = ap;
      m_ret++;
    end else if (op == 4'hC) begin
      m_pc = m_pred ? PC_W'(ins[7:0]) : m_pc + 1'b1;
      m_ret++;
    end else if (op == 4'hD) begin
      m_pc = PC_W'(ins[7:0]);
      m_ret++;
    end else if (op == 4'h0) begin
      m_pc = m_pc + 1'b1;
      m_ret++;
    end else if (op == 4'hE) begin
      for (int i = 0; i <= wait_n; i++) begin
        @(negedge clk);
        chk("sync_req_wait", 32'(sync_req), 32'd1);
        chk("sync_busy", 32'(busy), 32'd1);
        chk("sync_no_fetch", 32'(imem_en), 32'd0);
        if (i == wait_n) sync_go = 1'b1;
      end
      m_pc = m_pc + 1'b1;
      m_ret++;
    end else begin
      @(negedge clk);
      m_ret++;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_alu_hold", 32'(alu_c), 32'hF);
      chk("halt_retired", 32'(instr_retired), exp_ret());
    end
  endtask

  // Abort if something stalls far beyond the expected run length.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; alu_p = 1'b0; sync_go = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h7012;
    mem[1] = 16'h3312;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'(START_PC));
    chk("rst_alu_c", 32'(alu_c), 32'hF);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_pred", 32'(pred), 32'd0);
    chk("rst_sync_req", 32'(sync_req), 32'd0);
    chk("rst_retired", 32'(instr_retired), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // SETP sets pred, then reset lands in the middle of the ADD writeback.
    m_pc = START_PC; m_pred = 1'b0; m_ret = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'($urandom), 1'b1, 0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("midwb_rf_we", 32'(rf_we), 32'd0);
    chk("midwb_alu_c", 32'(alu_c), 32'hF);
    chk("midwb_pred", 32'(pred), 32'd0);
    chk("midwb_busy", 32'(busy), 32'd0);
    chk("midwb_imem_addr", 32'(imem_addr), 32'(START_PC));
    chk("midwb_retired", 32'(instr_retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = START_PC; m_pred = 1'b0; m_ret = 16'h0000;

    // Main program.
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'hC040;
    mem[8'h01] = 16'h3312;
    mem[8'h02] = 16'h7012;
    mem[8'h03] = 16'hC020;
    mem[8'h20] = 16'h7012;
    mem[8'h21] = 16'hC050;
    for (int k = 0; k < 8; k++) begin
      logic [3:0]  rop;
      logic [11:0] rfld;
      rop  = 4'($urandom_range(0, 11));
      rfld = 12'($urandom);
      mem[8'h22 + k] = {rop, rfld};
      rnd_p[k] = 1'($urandom);
    end
    mem[8'h2A] = 16'h6012;
    mem[8'h2B] = 16'hD0FF;
    mem[8'hFF] = 16'h0000;
    mem[8'h40] = 16'h2400;
    mem[8'h41] = 16'hE000;
    mem[8'h42] = 16'h1700;
    mem[8'h43] = 16'hF000;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    step(1'($urandom), 1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(rnd_p[k], 1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 5, 1'b0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);

    @(negedge clk);
    chk("halted_stays", 32'(halted), 32'd1);
    chk("halted_no_fetch", 32'(imem_en), 32'd0);

    // Restart from HALTED: counter keeps running, pred survives.
    start = 1'b1;
    @(posedge clk);
    m_pc = START_PC;
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
